axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI4 read channel (AR/R) between the cache refill requesters (ICache, DCache, uncached loads).
- One read burst is outstanding at a time. The grant is held from AR issue until the R beat carrying r_last completes.
- Sits between the cache FSMs and the top-level AXI4 master port.
- Counts R beats against the granted ar_len and flags protocol errors.

Parameters:
- REQ_NUM, 2, number of requesters (index 0 = highest fixed priority).
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width.
- ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= REQ_NUM.

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  asynchronous active-low reset.
- s_ar_valid  in  REQ_NUM  per-requester AR valid.
- s_ar_addr  in  REQ_NUM*ADDR_WIDTH  per-requester AR address.
- s_ar_len  in  REQ_NUM*8  per-requester burst length minus 1.
- s_ar_size  in  REQ_NUM*3  per-requester beat size.
- s_ar_burst  in  REQ_NUM*2  per-requester burst type.
- s_ar_ready  out  REQ_NUM  per-requester AR accept; one-hot or zero.
- s_r_valid  out  REQ_NUM  per-requester R valid; one-hot or zero.
- s_r_data  out  DATA_WIDTH  R data, broadcast to all requesters.
- s_r_resp  out  2  R response, broadcast.
- s_r_last  out  1  R last, broadcast.
- s_r_ready  in  REQ_NUM  per-requester R ready.
- m_ar_valid / m_ar_ready  out / in  1  master AR handshake.
- m_ar_id  out  ID_WIDTH  index of the granted requester.
- m_ar_addr / m_ar_len / m_ar_size / m_ar_burst  out  ADDR_WIDTH / 8 / 3 / 2  AR fields of the granted requester.
- m_r_valid / m_r_ready  in / out  1  master R handshake.
- m_r_id  in  ID_WIDTH  R ID.
- m_r_data / m_r_resp / m_r_last  in  DATA_WIDTH / 2 / 1  R payload.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset: the FSM goes to IDLE and these are cleared: grant, beat count, last_grant = REQ_NUM-1, err_o. While in reset, all valid/ready outputs are 0 and m_ar_* fields are 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_ar_valid is set, register the winner in grant and go to ADDR.
  - Latency from s_ar_valid rising to m_ar_valid is 1 cycle.
  - No AR fields are captured in this state.
- ADDR:
  - m_ar_valid = 1.
  - m_ar_* fields are muxed combinationally from requester grant; m_ar_id = grant.
  - s_ar_ready[grant] = m_ar_ready.
  - When m_ar_valid & m_ar_ready: capture len_q = s_ar_len[grant], clear the beat count, go to DATA.
  - The requester must hold s_ar_valid and its fields stable until accepted. If s_ar_valid[grant] drops while in ADDR, set err_o and still complete the transaction.
- DATA:
  - s_r_valid[grant] = m_r_valid; m_r_ready = s_r_ready[grant]; all other s_r_valid bits are 0.
  - On every R handshake, the beat count increments (8-bit, no wrap needed since len <= 255).
  - On an R handshake with m_r_last: go to IDLE and update last_grant = grant.
  - err_o is set on any of: m_r_last arriving on a beat where beat count != len_q; beat count reaching len_q without m_r_last; m_r_id != grant.
- No new AR is issued until DATA exits; back-to-back bursts have 1 IDLE cycle between them.
- Simultaneous requests are resolved by the arbitration policy below. A request that arrives in the same cycle that DATA exits waits for the IDLE cycle.
- A requester that is flushed must still drain its R beats (the ICache keeps its FSM running to r_last). The arbiter never aborts a burst.
- Asynchronous reset mid-burst returns the FSM to IDLE immediately. Downstream beats still in flight are the system's responsibility, since the AXI slave is reset by the same a_rst_n.
- s_r_data / s_r_resp / s_r_last are passed through combinationally; no R buffering, zero added R latency.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last_grant+1) mod REQ_NUM and takes the first set s_ar_valid.
- Undefined: fixed priority, lowest index wins. last_grant is then unused and may be optimised away.

Test Plan:
- Single requester 1 asserts AR with addr=0x1C000040, len=3; slave accepts in ADDR on the first cycle -> m_ar_valid 1 cycle after request, m_ar_id=1. Four beats appear on s_r_valid[1] only, busy_o falls the cycle after the last beat, err_o=0.
- Requesters 0 and 1 request simultaneously, twice in a row -> fixed priority: 0 then 0. With AXI_RD_ARB_RR_EN defined: 0 then 1.
- m_ar_ready held low for 5 cycles -> m_ar_valid and fields stay stable, s_ar_ready stays 0, and exactly one AR handshake occurs.
- Slave asserts r_last on beat 2 of a len=3 burst -> err_o=1 and stays set; FSM returns to IDLE.
- s_r_ready[0] toggles 1,0,1,0 during a 4-beat burst -> m_r_ready mirrors it, no beat is lost, beat count reaches 3.
- a_rst_n asserted in DATA after 2 beats -> all outputs are 0 immediately; after release, a new request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between REQ_NUM requesters, with one burst outstanding at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; the default is fixed priority (index 0 highest).
module axi_rd_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  input  logic [REQ_NUM-1:0]            s_ar_valid,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [REQ_NUM*8-1:0]          s_ar_len,
  input  logic [REQ_NUM*3-1:0]          s_ar_size,
  input  logic [REQ_NUM*2-1:0]          s_ar_burst,
  output logic [REQ_NUM-1:0]            s_ar_ready,
  output logic [REQ_NUM-1:0]            s_r_valid,
  output logic [DATA_WIDTH-1:0]         s_r_data,
  output logic [1:0]                    s_r_resp,
  output logic                          s_r_last,
  input  logic [REQ_NUM-1:0]            s_r_ready,
  output logic                          m_ar_valid,
  input  logic                          m_ar_ready,
  output logic [ID_WIDTH-1:0]           m_ar_id,
  output logic [ADDR_WIDTH-1:0]         m_ar_addr,
  output logic [7:0]                    m_ar_len,
  output logic [2:0]                    m_ar_size,
  output logic [1:0]                    m_ar_burst,
  input  logic                          m_r_valid,
  output logic                          m_r_ready,
  input  logic [ID_WIDTH-1:0]           m_r_id,
  input  logic [DATA_WIDTH-1:0]         m_r_data,
  input  logic [1:0]                    m_r_resp,
  input  logic                          m_r_last,
  output logic                          busy_o,
  output logic                          err_o
);
  localparam int GW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [7:0]      beat_cnt;
  logic [7:0]      len_q;
  logic            err_q;
  logic            ar_hs;
  logic            r_hs;
  logic            r_bad;

  logic [ADDR_WIDTH-1:0] addr_a  [REQ_NUM];
  logic [7:0]            len_a   [REQ_NUM];
  logic [2:0]            size_a  [REQ_NUM];
  logic [1:0]            burst_a [REQ_NUM];

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
    assign addr_a[g]  = s_ar_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[g]   = s_ar_len[g*8 +: 8];
    assign size_a[g]  = s_ar_size[g*3 +: 3];
    assign burst_a[g] = s_ar_burst[g*2 +: 2];
  end

`ifdef AXI_RD_ARB_RR_EN
  logic [GW-1:0] last_grant;

  // Walk from the farthest candidate to the nearest so the first set bit after last wins.
  function automatic logic [GW-1:0] pick(input logic [REQ_NUM-1:0] v, input logic [GW-1:0] last);
    logic [GW-1:0] w;
    logic [GW-1:0] idx;
    w = '0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % REQ_NUM);
      if (v[idx]) w = idx;
    end
    return w;
  endfunction
`else
  function automatic logic [GW-1:0] pick(input logic [REQ_NUM-1:0] v);
    logic [GW-1:0] w;
    w = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (v[GW'(k)]) w = GW'(k);
    end
    return w;
  endfunction
`endif

  assign ar_hs  = (state == ADDR) && m_ar_ready;
  assign r_hs   = (state == DATA) && m_r_valid && s_r_ready[grant];
  assign r_bad  = (m_r_last && (beat_cnt != len_q)) ||
                  (!m_r_last && (beat_cnt == len_q)) ||
                  (m_r_id != ID_WIDTH'(grant));
  assign busy_o = (state != IDLE);
  assign err_o  = err_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
      last_grant <= GW'(REQ_NUM - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|s_ar_valid) begin
`ifdef AXI_RD_ARB_RR_EN
            grant <= pick(s_ar_valid, last_grant);
`else
            grant <= pick(s_ar_valid);
`endif
            state <= ADDR;
          end
        end
        ADDR: begin
          // A requester withdrawing its request is an error, but the burst still completes.
          if (!s_ar_valid[grant]) err_q <= 1'b1;
          if (m_ar_ready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (r_bad) err_q <= 1'b1;
            if (m_r_last) begin
              state <= IDLE;
`ifdef AXI_RD_ARB_RR_EN
              last_grant <= grant;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) len_q <= len_a[grant];
  end

  always_comb begin
    m_ar_valid = (state == ADDR);
    m_ar_id    = '0;
    m_ar_addr  = '0;
    m_ar_len   = '0;
    m_ar_size  = '0;
    m_ar_burst = '0;
    s_ar_ready = '0;
    s_r_valid  = '0;
    m_r_ready  = 1'b0;
    s_r_data   = '0;
    s_r_resp   = '0;
    s_r_last   = 1'b0;
    if (state == ADDR) begin
      m_ar_id           = ID_WIDTH'(grant);
      m_ar_addr         = addr_a[grant];
      m_ar_len          = len_a[grant];
      m_ar_size         = size_a[grant];
      m_ar_burst        = burst_a[grant];
      s_ar_ready[grant] = m_ar_ready;
    end
    if (state == DATA) begin
      s_r_valid[grant] = m_r_valid;
      m_r_ready        = s_r_ready[grant];
      s_r_data         = m_r_data;
      s_r_resp         = m_r_resp;
      s_r_last         = m_r_last;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (2 requesters); arbitration expectations follow AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;
  logic        clk;
  logic        a_rst_n;
  logic [1:0]  s_ar_valid;
  logic [63:0] s_ar_addr;
  logic [15:0] s_ar_len;
  logic [5:0]  s_ar_size;
  logic [3:0]  s_ar_burst;
  logic [1:0]  s_ar_ready;
  logic [1:0]  s_r_valid;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic [1:0]  s_r_ready;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [3:0]  m_ar_id;
  logic [31:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [2:0]  m_ar_size;
  logic [1:0]  m_ar_burst;
  logic        m_r_valid;
  logic        m_r_ready;
  logic [3:0]  m_r_id;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic        busy_o;
  logic        err_o;

  int vec;
  int miss;
  int ar_cnt;
  int r0_cnt;

  axi_rd_arbiter #(.REQ_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
    .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_r_last(s_r_last), .s_r_ready(s_r_ready),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_ar_valid && m_ar_ready) ar_cnt <= ar_cnt + 1;
    if (s_r_valid[0] && s_r_ready[0]) r0_cnt <= r0_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] g2;
    int         beats;
    int         hs0;
    int         rh0;
    logic       rdy;
`ifdef AXI_RD_ARB_RR_EN
    g2 = 2'd1;
`else
    g2 = 2'd0;
`endif
    vec = 0; miss = 0; ar_cnt = 0; r0_cnt = 0;
    a_rst_n = 1'b0; s_ar_valid = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0;
    s_ar_burst = '0; s_r_ready = '0; m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_id = '0;
    m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;
    settle();
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("rst_s_r_valid", 64'(s_r_valid), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
    tick(); tick();
    a_rst_n = 1'b1;
    tick();

    // single requester 1, len 3, immediate AR accept
    s_ar_valid = 2'b10; s_ar_addr[63:32] = 32'h1C000040; s_ar_len[15:8] = 8'd3;
    s_ar_size[5:3] = 3'd2; s_ar_burst[3:2] = 2'b01; m_ar_ready = 1'b1;
    settle();
    chk("t1_idle_ar_valid", 64'(m_ar_valid), 64'd0);
    tick();
    chk("t1_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("t1_ar_id", 64'(m_ar_id), 64'd1);
    chk("t1_ar_addr", 64'(m_ar_addr), 64'h1C000040);
    chk("t1_ar_len", 64'(m_ar_len), 64'd3);
    chk("t1_ar_size", 64'(m_ar_size), 64'd2);
    chk("t1_ar_burst", 64'(m_ar_burst), 64'd1);
    chk("t1_s_ar_ready", 64'(s_ar_ready), 64'd2);
    chk("t1_busy", 64'(busy_o), 64'd1);
    tick();
    s_ar_valid = 2'b00;
    settle();
    chk("t1_data_ar_valid", 64'(m_ar_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_id = 4'd1; m_r_data = 32'hD0000000 + 32'(i);
      m_r_last = (i == 3); s_r_ready = 2'b10;
      settle();
      chk("t1_s_r_valid", 64'(s_r_valid), 64'd2);
      chk("t1_m_r_ready", 64'(m_r_ready), 64'd1);
      chk("t1_s_r_data", 64'(s_r_data), 64'hD0000000 + 64'(i));
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t1_busy_fall", 64'(busy_o), 64'd0);
    chk("t1_err", 64'(err_o), 64'd0);

    // simultaneous requests, twice
    s_ar_valid = 2'b11; s_ar_addr = {32'h00002000, 32'h00001000}; s_ar_len = 16'h0000;
    settle();
    tick();
    chk("t2a_ar_id", 64'(m_ar_id), 64'd0);
    chk("t2a_ar_addr", 64'(m_ar_addr), 64'h1000);
    chk("t2a_s_ar_ready", 64'(s_ar_ready), 64'd1);
    tick();
    m_r_valid = 1'b1; m_r_id = 4'd0; m_r_last = 1'b1; s_r_ready = 2'b11;
    settle();
    chk("t2a_s_r_valid", 64'(s_r_valid), 64'd1);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t2_gap_ar_valid", 64'(m_ar_valid), 64'd0);
    tick();
    chk("t2b_ar_id", 64'(m_ar_id), 64'(g2));
    chk("t2b_ar_addr", 64'(m_ar_addr), (g2 == 2'd1) ? 64'h2000 : 64'h1000);
    tick();
    s_ar_valid = 2'b00; m_r_valid = 1'b1; m_r_id = 4'(g2); m_r_last = 1'b1;
    settle();
    chk("t2b_s_r_valid", 64'(s_r_valid), 64'd1 << g2);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t2_err", 64'(err_o), 64'd0);

    // AR stall for 5 cycles
    hs0 = ar_cnt;
    s_ar_valid = 2'b01; s_ar_addr[31:0] = 32'h80000100; s_ar_len[7:0] = 8'd1; m_ar_ready = 1'b0;
    settle();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ar_valid", 64'(m_ar_valid), 64'd1);
      chk("t3_stall_ar_addr", 64'(m_ar_addr), 64'h80000100);
      chk("t3_stall_s_ar_ready", 64'(s_ar_ready), 64'd0);
      tick();
    end
    m_ar_ready = 1'b1;
    settle();
    chk("t3_s_ar_ready", 64'(s_ar_ready), 64'd1);
    tick();
    s_ar_valid = 2'b00;
    settle();
    chk("t3_ar_hs_count", 64'(ar_cnt - hs0), 64'd1);
    for (int i = 0; i < 2; i++) begin
      m_r_valid = 1'b1; m_r_id = 4'd0; m_r_last = (i == 1); s_r_ready = 2'b01;
      settle();
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t3_busy", 64'(busy_o), 64'd0);
    chk("t3_err", 64'(err_o), 64'd0);

    // R backpressure toggling on requester 0
    s_ar_valid = 2'b01; s_ar_len[7:0] = 8'd3;
    settle();
    tick(); tick();
    s_ar_valid = 2'b00;
    beats = 0; rh0 = r0_cnt;
    for (int c = 0; c < 8 && beats < 4; c++) begin
      rdy = ((c % 2) == 0);
      m_r_valid = 1'b1; m_r_id = 4'd0; m_r_data = 32'hA0 + 32'(beats);
      m_r_last = (beats == 3); s_r_ready = {1'b0, rdy};
      settle();
      chk("t5_m_r_ready", 64'(m_r_ready), 64'(rdy));
      chk("t5_s_r_data", 64'(s_r_data), 64'hA0 + 64'(beats));
      tick();
      if (rdy) beats++;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t5_beats", 64'(r0_cnt - rh0), 64'd4);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_err", 64'(err_o), 64'd0);

    // early r_last on a len 3 burst
    s_ar_valid = 2'b01;
    settle();
    tick(); tick();
    s_ar_valid = 2'b00;
    m_r_valid = 1'b1; m_r_id = 4'd0; m_r_last = 1'b0; m_r_resp = 2'b10; s_r_ready = 2'b01;
    settle();
    chk("t4_s_r_resp", 64'(s_r_resp), 64'd2);
    tick();
    m_r_last = 1'b1;
    settle();
    chk("t4_s_r_last", 64'(s_r_last), 64'd1);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_resp = 2'b00;
    settle();
    chk("t4_err_set", 64'(err_o), 64'd1);
    chk("t4_idle", 64'(busy_o), 64'd0);
    tick(); tick();
    chk("t4_err_sticky", 64'(err_o), 64'd1);

    // async reset mid-burst
    s_ar_valid = 2'b10; s_ar_addr[63:32] = 32'h1C000080; s_ar_len[15:8] = 8'd3;
    settle();
    tick(); tick();
    s_ar_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_r_valid = 1'b1; m_r_id = 4'd1; m_r_data = 32'h55 + 32'(i); m_r_last = 1'b0; s_r_ready = 2'b10;
      settle();
      tick();
    end
    settle();
    chk("t6_pre_s_r_valid", 64'(s_r_valid), 64'd2);
    a_rst_n = 1'b0;
    settle();
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_s_r_valid", 64'(s_r_valid), 64'd0);
    chk("t6_rst_m_r_ready", 64'(m_r_ready), 64'd0);
    chk("t6_rst_err", 64'(err_o), 64'd0);
    chk("t6_rst_s_r_data", 64'(s_r_data), 64'd0);
    chk("t6_rst_ar_valid", 64'(m_ar_valid), 64'd0);
    m_r_valid = 1'b0;
    tick();
    a_rst_n = 1'b1;
    s_ar_valid = 2'b01; s_ar_addr[31:0] = 32'h00002000; s_ar_len[7:0] = 8'd0;
    settle();
    chk("t6_idle_ar_valid", 64'(m_ar_valid), 64'd0);
    tick();
    chk("t6_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("t6_ar_id", 64'(m_ar_id), 64'd0);
    chk("t6_ar_addr", 64'(m_ar_addr), 64'h2000);
    tick();
    s_ar_valid = 2'b00; m_r_valid = 1'b1; m_r_id = 4'd0; m_r_last = 1'b1; s_r_ready = 2'b01;
    settle();
    chk("t6_s_r_valid", 64'(s_r_valid), 64'd1);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    settle();
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_err", 64'(err_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
